ai_matmul_accelerator: RTL and testbench
========================================

// Module: ai_matmul_accelerator
// PURPOSE
//  Wishbone-style slave that multiplies two signed 32-bit integer matrices (C = A x B), up to MAX_DIM x MAX_DIM.
//  - The host writes an opcode, dimensions and operands over the bus.
//  - The host then writes a "go" register and reads C back through the same port.
//  - Sits on the SoC bus as the accelerator peripheral; A, B and C are held in internal register/RAM arrays.
// PARAMETERS
//  MAX_DIM   16  maximum rows/cols of any matrix
//  IDX_BITS  4   index width = log2(MAX_DIM); row and col fields are each IDX_BITS wide
// PORTS
//  wb_clk_i   in   1   single clock, all logic on rising edge
//  wb_rst_i   in   1   reset, asynchronous, active-low
//  wb_addr_i  in   32  word address; only [2*IDX_BITS+1:0] decoded, upper bits ignored
//  wb_we_i    in   1   1 = write, 0 = read
//  wb_data_i  in   32  write data
//  wb_data_o  out  32  read data, valid while wb_ack = 1
//  wb_ack     out  1   one-cycle transfer acknowledge
//  wb_stb     in   4   request strobe; any nonzero value = access requested
// BEHAVIOUR
//  Address map (sel = addr[2*IDX_BITS+1:2*IDX_BITS], row = addr[2*IDX_BITS-1:IDX_BITS], col = addr[IDX_BITS-1:0]):
//   - sel=00: control registers, offsets 0..5 as listed below.
//   - sel=01: A[row][col], R/W.
//   - sel=10: B[row][col], R/W.
//   - sel=11: C[row][col], read-only; writes are acked and dropped.
//  Control registers (sel=00):
//   - 0 OP, R/W: 1 = matmul; any other value = no-op.
//   - 1 W_A, R/W: width of A.
//   - 2 H_A, R/W: height of A.
//   - 3 W_B, R/W: width of B.
//   - 4 H_B, R/W: height of B.
//   - 5 GO/STATUS: a write of any value starts an operation. A read returns {29'b0, error, done, busy}.
//   - Offsets 6..: reads return 0, writes are ignored.
//  Reset:
//   - All control registers, the A/B/C arrays, wb_ack and wb_data_o go to 0.
//   - State returns to IDLE, including when reset is asserted mid-compute; the partial C is discarded (zeroed).
//  Handshake:
//   - When wb_stb != 0 and wb_ack = 0, the slave asserts wb_ack for exactly one cycle.
//   - That ack occurs on the next rising edge (1-cycle latency), except for the C read stall described below.
//   - A write takes effect at the acking edge.
//   - On a read, wb_data_o holds the addressed word during the ack cycle.
//   - After the ack cycle, wb_ack drops for at least one cycle even if wb_stb is still high, so each access gets one ack.
//   - Values written to A/B read back unchanged.
//  FSM IDLE -> COMPUTE -> DONE:
//   - GO write in IDLE or DONE clears done and error, then checks the configuration.
//   - If OP = 1 and all dims are in 1..MAX_DIM and W_A == H_B: go to COMPUTE (busy = 1).
//   - Otherwise (OP != 1, a dim is 0 or > MAX_DIM, or W_A != H_B): go straight to DONE; error = 1 when OP = 1, C unchanged.
//   - A GO write during COMPUTE is acked and ignored.
//  COMPUTE:
//   - For i < H_A and j < W_B: C[i][j] = sum over k < W_A of A[i][k]*B[k][j].
//   - Products and the sum are signed, truncated to 32 bits (two's-complement wrap), so overflow wraps silently.
//   - One MAC per cycle, so latency = H_A*W_B*W_A cycles plus one cycle per C write-back.
//   - Entries of C outside H_A x W_B are untouched.
//   - Ends in DONE with done = 1 and busy = 0.
//  Bus access during COMPUTE:
//   - A read of C is stalled (no ack) until DONE, then served with the final value. Hosts can therefore read C right after GO with no polling.
//   - Writes to A, B or the dimension registers are acked and ignored.
//   - Control/status reads are served normally.
//  A row/col index beyond the current dims still addresses the physical array; no error is raised.
// TESTING
//  1 Configure OP=1 and all dims = 2. Load A = [-3 -15; -6 7], B = [9 -15; -2 -5]; read back A and B -> the same values. Write GO (0xFFFFFFFF), then read C -> [3 120; -68 55].
//  2 16x16: A = identity, B[i][j] = 16*i+j, GO -> C == B. Then B = identity -> C == A.
//  3 Set W_A=3, H_B=2, GO -> STATUS = 0b110 (error, done); C is unchanged from the previous run.
//  4 2x2 with A[0][0] = 0x7FFFFFFF, B[0][0] = 2, all other entries 0 -> C[0][0] = 0xFFFFFFFE (wrap).
//  5 Assert wb_rst_i low mid-COMPUTE -> STATUS = 0, C reads 0, OP/dims read 0, wb_ack = 0.
//  6 Handshake: hold wb_stb = 4'hF for 5 cycles -> exactly one ack, 1 cycle after the strobe rises. A C read issued during COMPUTE is acked only after done.

Source files
------------

// File: rtl/ai_matmul_accelerator.sv
// ai_matmul_accelerator: Wishbone-style slave computing C = A x B on signed 32-bit matrices, one MAC per cycle.
module ai_matmul_accelerator #(
    parameter int MAX_DIM  = 16,
    parameter int IDX_BITS = 4
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic [31:0] wb_addr_i,
    input  logic        wb_we_i,
    input  logic [31:0] wb_data_i,
    output logic [31:0] wb_data_o,
    output logic        wb_ack,
    input  logic [3:0]  wb_stb
);
    localparam int AW = 2 * IDX_BITS;
    localparam int N  = MAX_DIM * MAX_DIM;

    typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;

    state_t              state, state_nx;
    logic [31:0]         a_mem [N];
    logic [31:0]         b_mem [N];
    logic [31:0]         c_mem [N];
    logic [31:0]         op, w_a, h_a, w_b, h_b, acc, prod, ctrl_rd, rdata;
    logic [IDX_BITS-1:0] i, j, k;
    logic [1:0]          sel;
    logic [AW-1:0]       idx;
    logic                stall, take, wr, go, cfg_ok, last, busy, done, served, wb_phase, error;
    logic                i_end, j_end, k_end;
    logic                unused;

    function automatic logic dim_ok(input logic [31:0] d);
        return d != 32'd0 && d <= 32'(MAX_DIM);
    endfunction

    assign sel    = wb_addr_i[AW+1:AW];
    assign idx    = wb_addr_i[AW-1:0];
    assign unused = ^wb_addr_i[31:AW+2];
    // C reads wait out the computation so the host never sees a partial result
    assign stall  = sel == 2'b11 && !wb_we_i && busy;
    assign take   = |wb_stb && !served && !stall;
    assign wr     = take && wb_we_i;
    assign go     = wr && sel == 2'b00 && idx == AW'(5) && !busy;
    assign cfg_ok = op == 32'd1 && dim_ok(w_a) && dim_ok(h_a) && dim_ok(w_b) && dim_ok(h_b) && w_a == h_b;
    assign i_end  = i == IDX_BITS'(h_a - 32'd1);
    assign j_end  = j == IDX_BITS'(w_b - 32'd1);
    assign k_end  = k == IDX_BITS'(w_a - 32'd1);
    assign last   = busy && wb_phase && i_end && j_end;
    assign prod   = a_mem[{i, k}] * b_mem[{k, j}];

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) state <= IDLE;
        else           state <= state_nx;
    end

    always_comb begin
        state_nx = go ? (cfg_ok ? COMPUTE : DONE) : (last ? DONE : state);
    end

    always_comb begin
        busy = state == COMPUTE;
        done = state == DONE;
    end

    always_comb begin
        ctrl_rd = idx == AW'(0) ? op :
                  idx == AW'(1) ? w_a :
                  idx == AW'(2) ? h_a :
                  idx == AW'(3) ? w_b :
                  idx == AW'(4) ? h_b :
                  idx == AW'(5) ? {29'b0, error, done, busy} : '0;
        rdata   = sel == 2'b01 ? a_mem[idx] :
                  sel == 2'b10 ? b_mem[idx] :
                  sel == 2'b11 ? c_mem[idx] : ctrl_rd;
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            wb_ack    <= 1'b0;
            wb_data_o <= '0;
            served    <= 1'b0;
            error     <= 1'b0;
            op        <= '0;
            w_a       <= '0;
            h_a       <= '0;
            w_b       <= '0;
            h_b       <= '0;
            a_mem     <= '{default: '0};
            b_mem     <= '{default: '0};
        end else begin
            wb_ack <= take;
            // one ack per strobe assertion: re-arm only once the strobe drops
            served <= take || (served && |wb_stb);
            if (take && !wb_we_i) wb_data_o <= rdata;
            if (go) error <= op == 32'd1 && !cfg_ok;
            if (wr && sel == 2'b00 && idx == AW'(0)) op <= wb_data_i;
            if (wr && !busy) begin
                if (sel == 2'b00 && idx == AW'(1)) w_a <= wb_data_i;
                if (sel == 2'b00 && idx == AW'(2)) h_a <= wb_data_i;
                if (sel == 2'b00 && idx == AW'(3)) w_b <= wb_data_i;
                if (sel == 2'b00 && idx == AW'(4)) h_b <= wb_data_i;
                if (sel == 2'b01) a_mem[idx] <= wb_data_i;
                if (sel == 2'b10) b_mem[idx] <= wb_data_i;
            end
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            c_mem    <= '{default: '0};
            i        <= '0;
            j        <= '0;
            k        <= '0;
            acc      <= '0;
            wb_phase <= 1'b0;
        end else if (go) begin
            i        <= '0;
            j        <= '0;
            k        <= '0;
            acc      <= '0;
            wb_phase <= 1'b0;
        end else if (busy) begin
            if (!wb_phase) begin
                acc      <= acc + prod;
                k        <= k_end ? '0 : k + 1'b1;
                wb_phase <= k_end;
            end else begin
                c_mem[{i, j}] <= acc;
                acc           <= '0;
                wb_phase      <= 1'b0;
                j             <= j_end ? '0 : j + 1'b1;
                if (j_end) i <= i + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_ai_matmul_accelerator.sv
// tb_ai_matmul_accelerator: random and directed bus traffic checked against a matrix-level model.
module tb_ai_matmul_accelerator;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        we = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata_o;
    logic        ack;
    logic [3:0]  stb = '0;
    int          tests = 0;
    int          fails = 0;

    logic [31:0] ma [256];
    logic [31:0] mb [256];
    logic [31:0] mc [256];
    logic [31:0] mop, mwa, mha, mwb, mhb;
    logic        mdone, merr;
    logic        prev_ack = 1'b0;

    ai_matmul_accelerator dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst_n),
        .wb_addr_i(addr),
        .wb_we_i  (we),
        .wb_data_i(wdata),
        .wb_data_o(rdata_o),
        .wb_ack   (ack),
        .wb_stb   (stb)
    );

    always #5 clk = ~clk;

    function automatic logic [9:0] ad(input int s, input int r, input int c);
        return 10'(s * 256 + r * 16 + c);
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic mreset();
        for (int n = 0; n < 256; n++) begin
            ma[n] = '0;
            mb[n] = '0;
            mc[n] = '0;
        end
        {mop, mwa, mha, mwb, mhb} = '0;
        mdone = 1'b0;
        merr  = 1'b0;
    endtask

    task automatic mgo();
        logic        ok;
        logic [31:0] s;
        ok = mop == 1 && mwa >= 1 && mwa <= 16 && mha >= 1 && mha <= 16 &&
             mwb >= 1 && mwb <= 16 && mhb >= 1 && mhb <= 16 && mwa == mhb;
        merr  = mop == 1 && !ok;
        mdone = 1'b1;
        if (ok)
            for (int r = 0; r < int'(mha); r++)
                for (int c = 0; c < int'(mwb); c++) begin
                    s = '0;
                    for (int t = 0; t < int'(mwa); t++) s += ma[r*16+t] * mb[t*16+c];
                    mc[r*16+c] = s;
                end
    endtask

    task automatic mwrite(input logic [9:0] a, input logic [31:0] d);
        if (a[9:8] == 2'd1) ma[a[7:0]] = d;
        else if (a[9:8] == 2'd2) mb[a[7:0]] = d;
        else if (a[9:8] == 2'd0)
            case (a[7:0])
                8'd0: mop = d;
                8'd1: mwa = d;
                8'd2: mha = d;
                8'd3: mwb = d;
                8'd4: mhb = d;
                8'd5: mgo();
                default: ;
            endcase
    endtask

    function automatic logic [31:0] mread(input logic [9:0] a);
        if (a[9:8] == 2'd1) return ma[a[7:0]];
        if (a[9:8] == 2'd2) return mb[a[7:0]];
        if (a[9:8] == 2'd3) return mc[a[7:0]];
        case (a[7:0])
            8'd0: return mop;
            8'd1: return mwa;
            8'd2: return mha;
            8'd3: return mwb;
            8'd4: return mhb;
            8'd5: return {29'b0, merr, mdone, 1'b0};
            default: return '0;
        endcase
    endfunction

    task automatic xfer(input logic w, input logic [9:0] a, input logic [31:0] d,
                        output logic [31:0] q, output int lat);
        logic [31:0] r;
        @(negedge clk);
        r     = $urandom();
        addr  = {r[31:10], a};
        we    = w;
        wdata = d;
        stb   = 4'($urandom_range(1, 15));
        lat   = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!ack && lat < 20000);
        if (!ack) begin
            tests++;
            fails++;
            $display("FAIL ack_timeout: addr %h got no ack expected ack", a);
        end
        q   = rdata_o;
        stb = '0;
    endtask

    task automatic wr(input logic [9:0] a, input logic [31:0] d);
        logic [31:0] q;
        int          lat;
        xfer(1'b1, a, d, q, lat);
        mwrite(a, d);
    endtask

    task automatic rd(input string name, input logic [9:0] a);
        logic [31:0] q;
        int          lat;
        xfer(1'b0, a, '0, q, lat);
        chk(name, q, mread(a));
    endtask

    task automatic rdl(input string name, input logic [9:0] a, input logic [31:0] lit);
        logic [31:0] q;
        int          lat;
        xfer(1'b0, a, '0, q, lat);
        chk(name, q, lit);
        chk({name, "_model"}, mread(a), lit);
    endtask

    // every acked cycle must be followed by a non-ack cycle
    always @(negedge clk) begin
        if (rst_n && ack) begin
            tests++;
            if (prev_ack) begin
                fails++;
                $display("FAIL ack_pulse: got ack high 2 cycles expected 1");
            end
        end
        prev_ack = rst_n && ack;
    end

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int          av [4] = '{-3, -15, -6, 7};
        int          bv [4] = '{9, -15, -2, -5};
        int          cv [4] = '{3, 120, -68, 55};
        int          n_ack, first, lat, wa, ha, wbd, hb, mode;
        logic [31:0] q, opv;

        mreset();
        repeat (3) @(negedge clk);
        chk("rst_ack", {31'b0, ack}, 32'd0);
        chk("rst_data", rdata_o, 32'd0);
        rst_n = 1'b1;
        rdl("rst_status", ad(0, 0, 5), 32'd0);
        rdl("rst_op", ad(0, 0, 0), 32'd0);
        rd("rst_c", ad(3, 5, 7));

        wr(ad(0, 0, 0), 32'd1);
        for (int o = 1; o <= 4; o++) wr(ad(0, 0, o), 32'd2);
        for (int n = 0; n < 4; n++) begin
            wr(ad(1, n / 2, n % 2), av[n]);
            wr(ad(2, n / 2, n % 2), bv[n]);
        end
        for (int n = 0; n < 4; n++) begin
            rdl("t1_a", ad(1, n / 2, n % 2), av[n]);
            rdl("t1_b", ad(2, n / 2, n % 2), bv[n]);
        end
        wr(ad(0, 0, 5), 32'hFFFF_FFFF);
        for (int n = 0; n < 4; n++) rdl("t1_c", ad(3, n / 2, n % 2), cv[n]);
        rdl("t1_status", ad(0, 0, 5), 32'd2);

        @(negedge clk);
        addr  = 32'(ad(0, 0, 5));
        we    = 1'b0;
        stb   = 4'hF;
        n_ack = 0;
        first = 0;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (ack) begin
                n_ack++;
                if (first == 0) first = c;
            end
        end
        stb = '0;
        @(negedge clk);
        chk("hs_ack_count", n_ack, 32'd1);
        chk("hs_ack_latency", first, 32'd1);

        for (int it = 0; it < 8; it++) begin
            wa   = $urandom_range(1, 4);
            ha   = $urandom_range(1, 4);
            wbd  = $urandom_range(1, 4);
            hb   = wa;
            opv  = 32'd1;
            mode = $urandom_range(0, 5);
            if (mode == 0) hb = wa % 4 + 1;
            if (mode == 1) opv = $urandom_range(0, 1) ? 32'd0 : 32'd7;
            if (mode == 2) ha = $urandom_range(0, 1) ? 0 : 17;
            wr(ad(0, 0, 0), opv);
            wr(ad(0, 0, 1), wa);
            wr(ad(0, 0, 2), ha);
            wr(ad(0, 0, 3), wbd);
            wr(ad(0, 0, 4), hb);
            for (int r = 0; r < 5; r++)
                for (int c = 0; c < 5; c++) begin
                    wr(ad(1, r, c), $urandom());
                    wr(ad(2, r, c), $urandom());
                end
            wr(ad(0, 0, 5), $urandom());
            for (int r = 0; r < 5; r++)
                for (int c = 0; c < 5; c++) rd("rnd_c", ad(3, r, c));
            rd("rnd_status", ad(0, 0, 5));
        end

        wr(ad(0, 0, 0), 32'd1);
        for (int o = 1; o <= 4; o++) wr(ad(0, 0, o), 32'd16);
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++) begin
                wr(ad(1, r, c), r == c ? 32'd1 : 32'd0);
                wr(ad(2, r, c), 16 * r + c);
            end
        wr(ad(0, 0, 5), 32'd0);
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++) rdl("id_c_eq_b", ad(3, r, c), 16 * r + c);
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++) wr(ad(2, r, c), r == c ? 32'd1 : 32'd0);
        wr(ad(0, 0, 5), 32'd0);
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++) rdl("id_c_eq_a", ad(3, r, c), r == c ? 32'd1 : 32'd0);

        wr(ad(0, 0, 1), 32'd3);
        wr(ad(0, 0, 4), 32'd2);
        wr(ad(0, 0, 5), 32'd1);
        rdl("err_status", ad(0, 0, 5), 32'd6);
        rdl("err_c_kept", ad(3, 0, 0), 32'd1);
        rdl("err_c_kept2", ad(3, 15, 14), 32'd0);
        wr(ad(0, 0, 0), 32'd0);
        wr(ad(0, 0, 1), 32'd16);
        wr(ad(0, 0, 4), 32'd16);
        wr(ad(0, 0, 5), 32'd1);
        rdl("noop_status", ad(0, 0, 5), 32'd2);

        wr(ad(0, 0, 0), 32'd1);
        for (int o = 1; o <= 4; o++) wr(ad(0, 0, o), 32'd2);
        for (int n = 0; n < 4; n++) begin
            wr(ad(1, n / 2, n % 2), n == 0 ? 32'h7FFF_FFFF : 32'd0);
            wr(ad(2, n / 2, n % 2), n == 0 ? 32'd2 : 32'd0);
        end
        wr(ad(0, 0, 5), 32'd1);
        rdl("wrap_c00", ad(3, 0, 0), 32'hFFFF_FFFE);
        rdl("wrap_c11", ad(3, 1, 1), 32'd0);

        for (int o = 1; o <= 4; o++) wr(ad(0, 0, o), 32'd4);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                wr(ad(1, r, c), $urandom());
                wr(ad(2, r, c), $urandom());
            end
        wr(ad(0, 0, 5), 32'd1);
        xfer(1'b0, ad(0, 0, 5), '0, q, lat);
        chk("busy_status", q, 32'd1);
        xfer(1'b1, ad(1, 0, 0), ~ma[0], q, lat);
        xfer(1'b1, ad(0, 0, 1), 32'd1, q, lat);
        xfer(1'b0, ad(3, 3, 3), '0, q, lat);
        chk("stall_c33", q, mread(ad(3, 3, 3)));
        chk("stall_latency", 32'(lat >= 50), 32'd1);
        rd("busy_a_write_ignored", ad(1, 0, 0));
        rd("busy_dim_write_ignored", ad(0, 0, 1));
        rd("stall_status", ad(0, 0, 5));

        for (int o = 1; o <= 4; o++) wr(ad(0, 0, o), 32'd16);
        wr(ad(0, 0, 5), 32'd1);
        repeat (30) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_ack", {31'b0, ack}, 32'd0);
        chk("midrst_data", rdata_o, 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        mreset();
        rdl("midrst_status", ad(0, 0, 5), 32'd0);
        for (int o = 0; o <= 4; o++) rdl("midrst_ctrl", ad(0, 0, o), 32'd0);
        rdl("midrst_c00", ad(3, 0, 0), 32'd0);
        rdl("midrst_c33", ad(3, 3, 3), 32'd0);
        rdl("midrst_a00", ad(1, 0, 0), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
